mem_io_decoder: RTL and testbench

//  Registered successor to the combinational data-memory decoder. Splits each load/store into a

---
 rtl/mem_io_decoder.sv | 195 +++++++++++++++++++
 tb/tb_mem_io_decoder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_decoder.sv
// Registered load/store decoder: data-memory byte lanes or memory-mapped I/O channel with req/ack stall.
// Optional misalignment trap enabled by defining MISALIGN_CHK_EN.
module mem_io_decoder #(
  parameter int unsigned      AW         = 32,
  parameter int unsigned      IO_BASE    = 64,
  parameter int unsigned      IO_CH      = 4,
  parameter logic [IO_CH-1:0] IO_RD_MASK = IO_CH'(4'b1100),
  parameter int unsigned      TIMEOUT    = 15,
  localparam int unsigned     OPW        = $clog2(IO_CH) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  input  logic [AW-1:0]  aluout,
  input  logic [1:0]     writecontrol,
  input  logic [1:0]     readcontrol,
  input  logic           signcontrol,
  input  logic           io_ack,
  output logic [3:0]     wemen,
  output logic [3:0]     re,
  output logic [AW-1:0]  daddr,
  output logic           memdatamuxcontrol,
  output logic [OPW-1:0] opcode,
  output logic           sign_q,
  output logic           io_req,
  output logic           stall,
  output logic           io_err,
  output logic           misalign
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_IO_WAIT,
    S_IO_DONE
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [3:0]     r_wemen, w_wemen_nxt;
  logic [3:0]     r_re, w_re_nxt;
  logic [AW-1:0]  r_daddr, w_daddr_nxt;
  logic           r_mux, w_mux_nxt;
  logic [OPW-1:0] r_opcode, w_opcode_nxt;
  logic           r_sign, w_sign_nxt;
  logic           r_io_req, w_io_req_nxt;
  logic           r_stall, w_stall_nxt;
  logic           r_io_err, w_io_err_nxt;
  logic           r_misalign, w_misalign_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;

  logic           w_store;
  logic           w_load;
  logic [1:0]     w_size;
  logic [3:0]     w_lanes;
  logic           w_mis;
  logic [AW-1:0]  w_waddr;
  logic           w_in_win;
  logic [OPW-1:0] w_chan;
  logic           w_chan_rd;
  logic           w_io_legal;
  logic [CW-1:0]  w_cnt_inc;

  // Request decode: a store takes priority over a simultaneous load
  always_comb begin
    w_store = (writecontrol != 2'd3);
    w_load  = !w_store && (readcontrol != 2'd3);
    w_size  = w_store ? writecontrol : readcontrol;
    case (w_size)
      2'd0:    w_lanes = 4'b0001 << aluout[1:0];
      2'd1:    w_lanes = aluout[1] ? 4'b1100 : 4'b0011;
      2'd2:    w_lanes = 4'b1111;
      default: w_lanes = 4'b0000;
    endcase
`ifdef MISALIGN_CHK_EN
    w_mis = ((w_size == 2'd2) && (aluout[1:0] != 2'b00)) ||
            ((w_size == 2'd1) && aluout[0]);
`else
    w_mis = 1'b0;
`endif
    w_waddr   = aluout >> 2;
    w_in_win  = (w_waddr >= AW'(IO_BASE)) && (w_waddr < AW'(IO_BASE + IO_CH));
    w_chan    = OPW'(w_waddr - AW'(IO_BASE));
    w_chan_rd = 1'b0;
    for (int unsigned k = 0; k < IO_CH; k++) begin
      if (w_chan == OPW'(k)) w_chan_rd = IO_RD_MASK[k];
    end
    w_io_legal = w_in_win &&
                 (w_chan_rd ? (!w_store && (readcontrol == 2'd2)) : w_store);
    w_cnt_inc  = r_cnt + CW'(1);
  end

  // Next state and next registered outputs; idle values are the defaults
  always_comb begin
    w_state_nxt    = r_state;
    w_wemen_nxt    = 4'b0000;
    w_re_nxt       = 4'b0000;
    w_daddr_nxt    = '0;
    w_mux_nxt      = 1'b0;
    w_opcode_nxt   = OPW'(IO_CH);
    w_sign_nxt     = r_sign;
    w_io_req_nxt   = 1'b0;
    w_stall_nxt    = 1'b0;
    w_io_err_nxt   = 1'b0;
    w_misalign_nxt = 1'b0;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_sign_nxt = signcontrol;
          if (w_mis) begin
            w_misalign_nxt = 1'b1;
          end else if (w_in_win) begin
            if (w_io_legal) begin
              w_state_nxt  = S_IO_WAIT;
              w_opcode_nxt = w_chan;
              w_mux_nxt    = w_chan_rd;
              w_io_req_nxt = 1'b1;
              w_stall_nxt  = 1'b1;
              w_cnt_nxt    = '0;
            end
          end else if (w_store) begin
            w_wemen_nxt = w_lanes;
            w_daddr_nxt = w_waddr;
          end else if (w_load) begin
            w_re_nxt    = w_lanes;
            w_daddr_nxt = w_waddr;
          end
        end
      end
      S_IO_WAIT: begin
        w_opcode_nxt = r_opcode;
        w_mux_nxt    = r_mux;
        w_cnt_nxt    = w_cnt_inc;
        if (io_ack) begin
          w_state_nxt = S_IO_DONE;
        end else if (w_cnt_inc == CW'(TIMEOUT)) begin
          w_state_nxt  = S_IO_DONE;
          w_io_err_nxt = 1'b1;
        end else begin
          w_io_req_nxt = 1'b1;
          w_stall_nxt  = 1'b1;
        end
      end
      S_IO_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wemen    <= 4'b0000;
      r_re       <= 4'b0000;
      r_daddr    <= '0;
      r_mux      <= 1'b0;
      r_opcode   <= OPW'(IO_CH);
      r_sign     <= 1'b0;
      r_io_req   <= 1'b0;
      r_stall    <= 1'b0;
      r_io_err   <= 1'b0;
      r_misalign <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wemen    <= w_wemen_nxt;
      r_re       <= w_re_nxt;
      r_daddr    <= w_daddr_nxt;
      r_mux      <= w_mux_nxt;
      r_opcode   <= w_opcode_nxt;
      r_sign     <= w_sign_nxt;
      r_io_req   <= w_io_req_nxt;
      r_stall    <= w_stall_nxt;
      r_io_err   <= w_io_err_nxt;
      r_misalign <= w_misalign_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign wemen             = r_wemen;
  assign re                = r_re;
  assign daddr             = r_daddr;
  assign memdatamuxcontrol = r_mux;
  assign opcode            = r_opcode;
  assign sign_q            = r_sign;
  assign io_req            = r_io_req;
  assign stall             = r_stall;
  assign io_err            = r_io_err;
  assign misalign          = r_misalign;

endmodule

// File: tb/tb_mem_io_decoder.sv
// Scoreboard bench for mem_io_decoder: random loads/stores against an arithmetic reference model.
module tb_mem_io_decoder;

  localparam int TIMEOUT = 15;
  localparam int IO_BASE = 64;
  localparam int IO_CH   = 4;
  localparam logic [3:0] RD_MASK = 4'b1100;
  localparam int K_W = 0, K_R = 1, K_IO = 2, K_MIS = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] aluout;
  logic [1:0]  writecontrol;
  logic [1:0]  readcontrol;
  logic        signcontrol;
  logic        io_ack;
  logic [3:0]  wemen;
  logic [3:0]  re;
  logic [31:0] daddr;
  logic        memdatamuxcontrol;
  logic [2:0]  opcode;
  logic        sign_q;
  logic        io_req;
  logic        stall;
  logic        io_err;
  logic        misalign;

  mem_io_decoder dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .aluout(aluout),
    .writecontrol(writecontrol), .readcontrol(readcontrol), .signcontrol(signcontrol),
    .io_ack(io_ack), .wemen(wemen), .re(re), .daddr(daddr),
    .memdatamuxcontrol(memdatamuxcontrol), .opcode(opcode), .sign_q(sign_q),
    .io_req(io_req), .stall(stall), .io_err(io_err), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [3:0]  lanes;
    logic [31:0] daddr;
    logic [2:0]  opc;
    logic        mux;
    logic        sg;
    int          waitc;
    logic        err;
  } item_t;

  item_t sb[$];
  int    n_checks = 0;
  int    n_err    = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: access size in bytes, offset in word, window membership by word address
  function automatic void model(input logic [31:0] a, input logic [1:0] wc, input logic [1:0] rc,
                                input logic sg, input int d, output item_t it, output bit has);
    bit     store;
    int     size, nb, off, ch;
    longint w;
    it    = '{kind: 0, lanes: 4'h0, daddr: 32'h0, opc: 3'h0, mux: 1'b0, sg: 1'b0, waitc: 0, err: 1'b0};
    has   = 1'b0;
    store = (wc != 2'd3);
    size  = store ? int'(wc) : int'(rc);
    if (size == 3) return;
    nb    = 1 << size;
    off   = int'(a % 32'd4);
    it.sg = sg;
`ifdef MISALIGN_CHK_EN
    if (off % nb != 0) begin
      it.kind = K_MIS;
      has     = 1'b1;
      return;
    end
`endif
    w = longint'(a / 32'd4);
    if (w >= IO_BASE && w < IO_BASE + IO_CH) begin
      ch = int'(w) - IO_BASE;
      if (RD_MASK[ch] ? (!store && rc == 2'd2) : store) begin
        it.kind  = K_IO;
        it.opc   = 3'(ch);
        it.mux   = RD_MASK[ch];
        it.waitc = (d < TIMEOUT) ? d + 1 : TIMEOUT;
        it.err   = (d >= TIMEOUT);
        has      = 1'b1;
      end
      return;
    end
    it.kind  = store ? K_W : K_R;
    it.lanes = 4'(((1 << nb) - 1) << (off - off % nb));
    it.daddr = 32'(a / 32'd4);
    has      = 1'b1;
  endfunction

  // Issue one request; d is the I/O wait cycle in which io_ack is raised (>=TIMEOUT: never)
  task automatic do_req(input logic [31:0] a, input logic [1:0] wc, input logic [1:0] rc,
                        input logic sg, input int d);
    item_t it;
    bit    has;
    model(a, wc, rc, sg, d, it, has);
    if (has) sb.push_back(it);
    req_valid    = 1'b1;
    aluout       = a;
    writecontrol = wc;
    readcontrol  = rc;
    signcontrol  = sg;
    io_ack       = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    io_ack = 1'b0;
    if (has && it.kind == K_IO) begin
      for (int k = 0; k < TIMEOUT + 2; k++) begin
        io_ack = (k == d);
        @(posedge clk); #1;
        if (!stall) break;
      end
      io_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      io_ack    = 1'b0;
      req_valid = 1'b0;
    end
  endtask

  item_t cur;
  bit    in_io  = 1'b0;
  bit    mon_en = 1'b0;
  int    wait_cnt = 0;

  // Monitor: pops the scoreboard whenever the DUT presents an access
  always @(negedge clk) begin
    int act_kind;
    if (!rst_n || !mon_en) begin
      in_io = 1'b0;
    end else if (in_io) begin
      if (stall) begin
        wait_cnt++;
        chk("wait_state", {io_req, wemen, re}, {1'b1, 8'h00});
      end else begin
        chk("io_wait_cycles", wait_cnt, cur.waitc);
        chk("io_err", io_err, cur.err);
        chk("done_opcode", opcode, cur.opc);
        chk("done_mux", memdatamuxcontrol, cur.mux);
        chk("done_io_req", io_req, 0);
        in_io = 1'b0;
      end
    end else if (stall || wemen != 4'h0 || re != 4'h0 || misalign) begin
      act_kind = stall ? K_IO : misalign ? K_MIS : (wemen != 4'h0) ? K_W : K_R;
      if (sb.size() == 0) begin
        chk("unexpected_event", act_kind + 1, 0);
      end else begin
        cur = sb.pop_front();
        chk("kind", act_kind, cur.kind);
        case (cur.kind)
          K_W: begin
            chk("store_lanes", {wemen, re}, {cur.lanes, 4'h0});
            chk("store_daddr", daddr, cur.daddr);
            chk("store_opcode", opcode, 4);
          end
          K_R: begin
            chk("load_lanes", {wemen, re}, {4'h0, cur.lanes});
            chk("load_daddr", daddr, cur.daddr);
            chk("load_sign", sign_q, cur.sg);
            chk("load_mux", memdatamuxcontrol, 0);
          end
          K_IO: begin
            chk("io_opcode", opcode, cur.opc);
            chk("io_mux", memdatamuxcontrol, cur.mux);
            chk("io_req", io_req, 1);
            in_io    = stall;
            wait_cnt = 1;
          end
          default: begin
            chk("misalign_lanes", {wemen, re, stall}, 0);
          end
        endcase
      end
    end else begin
      chk("idle_state", {opcode, io_err, io_req, memdatamuxcontrol, daddr}, {3'd4, 35'h0});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    item_t it;
    bit    has;
    rst_n = 1'b0; req_valid = 1'b0; aluout = '0; writecontrol = 2'd3;
    readcontrol = 2'd3; signcontrol = 1'b0; io_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lanes", {wemen, re}, 0);
    chk("rst_daddr", daddr, 0);
    chk("rst_mux", memdatamuxcontrol, 0);
    chk("rst_opcode", opcode, 4);
    chk("rst_sign", sign_q, 0);
    chk("rst_io_req", io_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_flags", {io_err, misalign}, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    do_req(32'h23, 2'd0, 2'd3, 1'b0, 0);
    do_req(32'h22, 2'd3, 2'd1, 1'b1, 0);
    do_req(32'h24, 2'd2, 2'd2, 1'b0, 0);
    do_req(32'h104, 2'd2, 2'd3, 1'b0, 3);
    do_req(32'h108, 2'd3, 2'd2, 1'b1, 99);
    do_req(32'h10C, 2'd3, 2'd2, 1'b0, 0);
    do_req(32'h100, 2'd1, 2'd3, 1'b0, 14);
    do_req(32'h21, 2'd3, 2'd2, 1'b0, 0);
    do_req(32'h10C, 2'd3, 2'd0, 1'b0, 0);
    do_req(32'h108, 2'd2, 2'd3, 1'b0, 0);
    do_req(32'h100, 2'd3, 2'd3, 1'b0, 0);
    do_req(32'hFF, 2'd0, 2'd3, 1'b1, 0);
    do_req(32'h110, 2'd3, 2'd2, 1'b0, 0);
    req_valid = 1'b0;
    @(posedge clk); #1;

    repeat (300) begin
      case ($urandom_range(0, 3))
        0:       a = 32'h100 + 32'($urandom_range(0, 15));
        1:       a = 32'($urandom_range(0, 255));
        2:       a = ($urandom_range(0, 1) == 1) ? 32'hF0 + 32'($urandom_range(0, 15))
                                                 : 32'h110 + 32'($urandom_range(0, 15));
        default: a = $urandom();
      endcase
      do_req(a, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 18)));
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset while an I/O request is outstanding
    model(32'h100, 2'd2, 2'd3, 1'b0, 99, it, has);
    sb.push_back(it);
    req_valid = 1'b1; aluout = 32'h100; writecontrol = 2'd2; readcontrol = 2'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_stall", {stall, io_req}, 2'b11);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_io_req", io_req, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_opcode", opcode, 4);
    chk("midrst_lanes", {wemen, re}, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
